// File: rtl/bit_unstuffer.sv
// rtl/bit_unstuffer.sv - USB RX bit-stuffing detector/remover
// Counts RUN_VAL runs, drops the following stuff bit, flags violations, counts removed bits.
module bit_unstuffer #(
  parameter int   RUN_LEN     = 6,
  parameter logic RUN_VAL     = 1'b1,
  parameter bit   STOP_ON_ERR = 1'b1,
  parameter int   SCNT_W      = 8
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         clear,
  input  logic                         bit_valid,
  input  logic                         bit_in,
  output logic                         data_out,
  output logic                         data_valid,
  output logic                         d_stuff,
  output logic                         stuff_err,
  output logic                         err_flag,
  output logic [$clog2(RUN_LEN+1)-1:0] run_count,
  output logic [SCNT_W-1:0]            stuff_count
);

  localparam int CNT_W = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);

  typedef enum logic [1:0] {COUNT, EXPECT, ERROR} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   run_d;
  logic [SCNT_W-1:0]  scnt_d;
  logic               dout_d, dv_d, serr_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= COUNT;
      run_count   <= '0;
      stuff_count <= '0;
      data_out    <= 1'b0;
      data_valid  <= 1'b0;
      stuff_err   <= 1'b0;
    end else begin
      state       <= state_d;
      run_count   <= run_d;
      stuff_count <= scnt_d;
      data_out    <= dout_d;
      data_valid  <= dv_d;
      stuff_err   <= serr_d;
    end
  end

  always_comb begin
    state_d = state;
    run_d   = run_count;
    scnt_d  = stuff_count;
    dout_d  = data_out;
    dv_d    = 1'b0;
    serr_d  = 1'b0;
    if (clear) begin
      state_d = COUNT;
      run_d   = '0;
      scnt_d  = '0;
      dout_d  = 1'b0;
    end else if (bit_valid) begin
      case (state)
        COUNT: begin
          dout_d = bit_in;
          dv_d   = 1'b1;
          if (bit_in == RUN_VAL) begin
            run_d = run_count + CNT_W'(1);
            if (run_d == RUN_MAX) state_d = EXPECT;
          end else begin
            run_d = '0;
          end
        end
        EXPECT: begin
          if (bit_in != RUN_VAL) begin
            // Valid stuff bit: swallowed, only the counter records it
            run_d   = '0;
            state_d = COUNT;
            if (stuff_count != '1) scnt_d = stuff_count + SCNT_W'(1);
          end else begin
            serr_d = 1'b1;
            if (STOP_ON_ERR) begin
              state_d = ERROR;
            end else begin
              dout_d  = bit_in;
              dv_d    = 1'b1;
              run_d   = CNT_W'(1);
              state_d = COUNT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign d_stuff  = (state == EXPECT);
  assign err_flag = (state == ERROR);

endmodule

// File: doc/bit_unstuffer.md
# bit_unstuffer

Parametrised receive-side bit-stuffing detector and remover for the USB RX datapath. It sits between the NRZI decoder and the RX shift register. It counts consecutive decoded bits of a configurable polarity and flags the bit that follows a full run as a stuff bit. It drops that stuff bit from the data stream, flags stuffing violations, and keeps a saturating count of removed stuff bits for status.

## Interface
Parameters:
- RUN_LEN, 6, number of consecutive RUN_VAL bits after which one stuff bit is expected; legal range 2..15.
- RUN_VAL, 1'b1, bit value whose runs are counted; the stuff bit is ~RUN_VAL.
- STOP_ON_ERR, 1, 1 = a stuffing violation enters a sticky ERROR state until clear; 0 = flag the violation and continue.
- SCNT_W, 8, width of the removed-stuff-bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear; asserted at SYNC/EOP boundaries.
- bit_valid  in  1  one-cycle strobe marking a new decoded bit (shift_enable).
- bit_in  in  1  decoded data bit, sampled only when bit_valid = 1.
- data_out  out  1  registered non-stuff data bit.
- data_valid  out  1  one-cycle pulse; data_out holds a data bit.
- d_stuff  out  1  level; the next bit_valid bit is expected to be a stuff bit.
- stuff_err  out  1  one-cycle pulse on a stuffing violation.
- err_flag  out  1  sticky error, STOP_ON_ERR = 1 only; always 0 otherwise.
- run_count  out  CNT_W  current run length; CNT_W = $clog2(RUN_LEN+1).
- stuff_count  out  SCNT_W  removed stuff bits since reset/clear; saturates at all-ones.

## Operation
- States:
  - COUNT: reset/default state.
  - EXPECT: one stuff bit pending; d_stuff = 1 exactly while in EXPECT.
  - ERROR: exists only when STOP_ON_ERR = 1.
- Nothing changes in any cycle with bit_valid = 0 and clear = 0. The exception is data_valid and stuff_err, which return to 0.
- COUNT, bit_valid = 1:
  - data_out = bit_in; data_valid pulses.
  - If bit_in = RUN_VAL, run_count increments. If the new value equals RUN_LEN, go to EXPECT.
  - Otherwise run_count = 0.
- EXPECT, bit_valid = 1, bit_in = ~RUN_VAL:
  - The bit is a valid stuff bit. It is dropped, so no data_valid.
  - run_count = 0; stuff_count increments, saturating; go to COUNT.
- EXPECT, bit_valid = 1, bit_in = RUN_VAL:
  - stuff_err pulses.
  - STOP_ON_ERR = 1: go to ERROR, err_flag = 1, no data_valid, run_count holds RUN_LEN.
  - STOP_ON_ERR = 0: the bit is passed as data (data_valid pulses), run_count = 1, go to COUNT.
- ERROR: all bit_valid strobes are ignored; no data_valid and no further stuff_err. Only clear or nrst exits.
- clear = 1, synchronous, highest priority in any state:
  - state = COUNT.
  - run_count, stuff_count, d_stuff, err_flag, data_valid and stuff_err all go to 0.
  - A bit_valid in the same cycle is discarded.
- Reset (nrst = 0, asynchronous): identical register values to clear. Reset mid-run discards the partial run and any pending stuff expectation.

## Timing
- All outputs are registered. Responses appear on the rising edge that samples bit_valid = 1, so latency is 1 clk.
- d_stuff rises in the same edge as the data_valid of the RUN_LEN-th RUN_VAL bit. It falls on the edge that consumes the next bit.
- Back-to-back bit_valid on every clk is supported; there is no throughput limit.
- stuff_count at saturation holds its value; further stuff bits are still removed.
- Reset values:
  - data_out, data_valid, d_stuff, stuff_err, err_flag = 0.
  - run_count = 0, stuff_count = 0.
  - state = COUNT.

## Test plan
- Defaults, 6 ones then 0, one bit per cycle -> 6 data_valid pulses, d_stuff = 1 after the 6th, 0 dropped (no data_valid), run_count = 0, stuff_count = 1.
- Defaults, 5 ones, 0, 6 ones, 0 -> 12 data_valid pulses; only the final 0 is removed; stuff_count = 1; stuff_err never asserts.
- STOP_ON_ERR = 1, 7 ones -> stuff_err pulse on the 7th, err_flag = 1. The next 4 bits give no data_valid. clear returns to COUNT with all outputs 0.
- STOP_ON_ERR = 0, RUN_VAL = 0, RUN_LEN = 3, bits 0,0,0,0,1 -> stuff_err on the 4th bit, 5 data_valid pulses, run_count = 0 after the 1.
- Defaults, 4 ones, then nrst pulse mid-bit, then 6 ones and 0 -> no stuff detection before the 10th bit; counting restarts from 0; stuff_count = 1.
- SCNT_W = 2, five valid stuff sequences -> stuff_count saturates at 3. The final stuff bit is still dropped. clear coincident with bit_valid drops the bit and zeros everything.
